spi_ram_bridge: RTL and testbench



---
 rtl/spi_ram_bridge_pkg.sv | 22 ++
 rtl/spi_ram_bridge_if.sv | 31 +++
 rtl/spi_ram_bridge_sync.sv | 37 +++
 rtl/spi_ram_bridge.sv | 189 ++++++++++++++++++
 tb/tb_spi_ram_bridge.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_bridge_pkg.sv
// spi_ram_pkg: shared types and constants for the SPI-to-RAM bridge.
//   state_e     - bridge FSM states
//   BYTE_W      - SPI / RAM data width
//   CMD_WR_DEF  - default write opcode
//   CMD_RD_DEF  - default read opcode
package spi_ram_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_WR_DEF = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_RD_DEF = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_ram_bridge_if.sv
// spi_ram_bridge_if: bus between the bridge (master) and a Gowin_SP style
// single-port RAM (slave).
//   ram_ce   - clock enable, one-cycle pulse per access
//   ram_oce  - output register enable
//   ram_wre  - write enable, meaningful only with ram_ce
//   ram_ad   - address
//   ram_din  - write data
//   ram_dout - read data, valid one clk after a read pulse
interface spi_ram_bridge_if #(
  parameter int ADDR_W = 8
);
  import spi_ram_pkg::*;

  logic              ram_ce;
  logic              ram_oce;
  logic              ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [BYTE_W-1:0] ram_din;
  logic [BYTE_W-1:0] ram_dout;

  modport master (
    output ram_ce, ram_oce, ram_wre, ram_ad, ram_din,
    input  ram_dout
  );

  modport slave (
    input  ram_ce, ram_oce, ram_wre, ram_ad, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/spi_ram_bridge_sync.sv
// spi_pin_sync: multi-flop synchroniser for one asynchronous pin plus
// rise/fall detection on the synchronised level.
//   clk, rst_n - system clock, async active-low reset
//   pin_i      - asynchronous input pin
//   level_o    - synchronised level
//   rise_o     - one-clk pulse on a synchronised 0->1 transition
//   fall_o     - one-clk pulse on a synchronised 1->0 transition
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge: SPI mode-0 slave that drives a 256x8 single-port RAM.
// Transaction: opcode byte, address byte, then data bytes with address
// auto-increment. Writes are single-cycle RAM pulses; reads are prefetched
// so the next byte is ready before the host clocks it out.
//   clk, rst_n         - system clock (>= 8x sclk), async active-low reset
//   spi_sclk/cs_n/mosi - SPI inputs, oversampled in the clk domain
//   spi_miso           - SPI output, MSB first
//   ram                - RAM bus (master side)
//   busy               - synchronised chip select is active
//   cmd_err            - sticky unknown-opcode flag, cleared at next select
module spi_ram_bridge
  import spi_ram_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] CMD_WR      = CMD_WR_DEF,
  parameter logic [BYTE_W-1:0] CMD_RD      = CMD_RD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  spi_ram_bridge_if.master ram,
  output logic             busy,
  output logic             cmd_err
);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [BYTE_W-2:0] rx_q;
  logic [BYTE_W-2:0] tx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ad_q;
  logic [BYTE_W-1:0] din_q;
  logic              is_wr_q, rd_p1_q;
  logic              miso_q, ce_q, oce_q, wre_q, busy_q, err_q;

  logic [BYTE_W-1:0] rx_byte_d;
  logic              byte_done_d;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (spi_sclk),
    .level_o(sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // cs_n idles high, so its synchroniser resets high to avoid a false select.
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (spi_cs_n),
    .level_o(cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Same depth as sclk, so mosi is aligned with the detected rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end

  assign rx_byte_d   = {rx_q, mosi_sync_q[SYNC_STAGES-1]};
  assign byte_done_d = sclk_rise && (state_q != IDLE) && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      ad_q      <= '0;
      din_q     <= '0;
      is_wr_q   <= 1'b0;
      rd_p1_q   <= 1'b0;
      miso_q    <= 1'b0;
      ce_q      <= 1'b0;
      oce_q     <= 1'b0;
      wre_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ce_q    <= 1'b0;
      wre_q   <= 1'b0;
      oce_q   <= 1'b1;
      busy_q  <= ~cs_lvl;
      rd_p1_q <= ce_q & ~wre_q;

      if (sclk_rise && state_q != IDLE) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        rx_q      <= rx_byte_d[BYTE_W-2:0];
      end

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
          end
        end
        CMD: begin
          if (byte_done_d) begin
            if (rx_byte_d == CMD_WR) begin
              is_wr_q <= 1'b1;
              state_q <= ADDR;
            end else if (rx_byte_d == CMD_RD) begin
              is_wr_q <= 1'b0;
              state_q <= ADDR;
            end else begin
              state_q <= IGNORE;
              err_q   <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (byte_done_d) begin
            addr_q <= ADDR_W'(rx_byte_d);
            if (is_wr_q) begin
              state_q <= WDATA;
            end else begin
              ce_q    <= 1'b1;
              ad_q    <= ADDR_W'(rx_byte_d);
              state_q <= RDATA;
            end
          end
        end
        WDATA: begin
          if (byte_done_d) begin
            ce_q   <= 1'b1;
            wre_q  <= 1'b1;
            ad_q   <= addr_q;
            din_q  <= rx_byte_d;
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        RDATA: begin
          // Prefetch the byte the host will clock out next.
          if (byte_done_d) begin
            ce_q   <= 1'b1;
            ad_q   <= addr_q + ADDR_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase

      // Deselect wins over the state update; a write completed in the same
      // clk is still committed, but a read prefetch is pointless and dropped.
      if (cs_rise && state_q != IDLE) begin
        state_q <= IDLE;
        if (state_q != WDATA) ce_q <= 1'b0;
      end

      // Bit 7 is presented as soon as the prefetch lands; the following
      // falling edges (bit counter 1..7) shift out bits 6..0. The falling
      // edge right after a byte boundary must not shift.
      if (state_q != RDATA) begin
        miso_q <= 1'b0;
      end else if (rd_p1_q) begin
        miso_q <= ram.ram_dout[BYTE_W-1];
        tx_q   <= ram.ram_dout[BYTE_W-2:0];
      end else if (sclk_fall && bit_cnt_q != 3'd0) begin
        miso_q <= tx_q[BYTE_W-2];
        tx_q   <= {tx_q[BYTE_W-3:0], 1'b0};
      end
    end
  end

  assign spi_miso    = miso_q;
  assign ram.ram_ce  = ce_q;
  assign ram.ram_oce = oce_q;
  assign ram.ram_wre = wre_q;
  assign ram.ram_ad  = ad_q;
  assign ram.ram_din = din_q;
  assign busy        = busy_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Directed testbench for spi_ram_bridge with a behavioural single-port RAM.
module tb_spi_ram_bridge;
  import spi_ram_pkg::*;

  logic clk;
  logic rst_n;
  logic spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic busy, cmd_err;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic load_mem;
  logic [7:0] mem [0:255];

  spi_ram_bridge_if #(.ADDR_W(8)) ram_if ();

  spi_ram_bridge dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .ram     (ram_if.master),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h00:   return 8'hA5;
      8'h01:   return 8'h32;
      8'h02:   return 8'h54;
      8'h03:   return 8'h76;
      default: return a;
    endcase
  endfunction

  // RAM model: registered read, data valid the clk after the ce pulse.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (ram_if.ram_ce) begin
      if (ram_if.ram_wre) begin
        mem[ram_if.ram_ad] <= ram_if.ram_din;
        wr_cnt++;
      end else begin
        ram_if.ram_dout <= mem[ram_if.ram_ad];
        rd_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode 0: host drives mosi while sclk is low, samples miso at the rise.
  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #60;
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      #60;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      #60;
      spi_sclk = 1'b1;
      #60;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #120;
  endtask

  task automatic cs_high();
    #60;
    spi_cs_n = 1'b1;
    #200;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] acc;
    int rd0, wr0;

    rst_n    = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    load_mem = 1'b1;
    #20;
    load_mem = 1'b0;

    // Reset state
    check("rst_outputs",
          {24'd0, spi_miso, ram_if.ram_ce, ram_if.ram_oce, ram_if.ram_wre, busy, cmd_err, 2'b00}, 32'd0);
    check("rst_ad_din", {16'd0, ram_if.ram_ad, ram_if.ram_din}, 32'd0);
    rst_n = 1'b1;
    #100;
    check("oce_after_rst", {31'd0, ram_if.ram_oce}, 32'd1);

    // Read 4 bytes from 0x00
    rd0 = rd_cnt; wr0 = wr_cnt;
    cs_low();
    check("busy_selected", {31'd0, busy}, 32'd1);
    spi_xfer(8'h03, rx);
    check("miso_cmd_phase", {24'd0, rx}, 32'd0);
    spi_xfer(8'h00, rx);
    spi_xfer(8'h00, rx); check("rd0_byte0", {24'd0, rx}, 32'hA5);
    spi_xfer(8'h00, rx); check("rd0_byte1", {24'd0, rx}, 32'h32);
    spi_xfer(8'h00, rx); check("rd0_byte2", {24'd0, rx}, 32'h54);
    spi_xfer(8'h00, rx); check("rd0_byte3", {24'd0, rx}, 32'h76);
    cs_high();
    check("rd0_pulses", rd_cnt - rd0, 32'd5);
    check("rd0_no_write", wr_cnt - wr0, 32'd0);
    check("busy_released", {31'd0, busy}, 32'd0);

    // Write across the address wrap
    rd0 = rd_cnt; wr0 = wr_cnt;
    cs_low();
    spi_xfer(8'h02, rx);
    spi_xfer(8'hFE, rx);
    spi_xfer(8'h11, rx); check("miso_wdata", {24'd0, rx}, 32'd0);
    spi_xfer(8'h22, rx);
    spi_xfer(8'h33, rx);
    cs_high();
    check("wr_pulses", wr_cnt - wr0, 32'd3);
    check("wr_no_read", rd_cnt - rd0, 32'd0);
    check("mem_fe", {24'd0, mem[8'hFE]}, 32'h11);
    check("mem_ff", {24'd0, mem[8'hFF]}, 32'h22);
    check("mem_00", {24'd0, mem[8'h00]}, 32'h33);

    rd0 = rd_cnt;
    cs_low();
    spi_xfer(8'h03, rx);
    spi_xfer(8'hFE, rx);
    spi_xfer(8'h00, rx); check("rdwrap_byte0", {24'd0, rx}, 32'h11);
    spi_xfer(8'h00, rx); check("rdwrap_byte1", {24'd0, rx}, 32'h22);
    spi_xfer(8'h00, rx); check("rdwrap_byte2", {24'd0, rx}, 32'h33);
    cs_high();
    check("rdwrap_pulses", rd_cnt - rd0, 32'd4);

    // Unknown opcode
    rd0 = rd_cnt; wr0 = wr_cnt;
    acc = 8'h00;
    cs_low();
    spi_xfer(8'h9F, rx); acc = acc | rx;
    spi_xfer(8'hFF, rx); acc = acc | rx;
    spi_xfer(8'h5A, rx); acc = acc | rx;
    spi_xfer(8'hFF, rx); acc = acc | rx;
    check("bad_cmd_err_active", {31'd0, cmd_err}, 32'd1);
    cs_high();
    check("bad_cmd_miso", {24'd0, acc}, 32'd0);
    check("bad_cmd_no_ram", (rd_cnt - rd0) + (wr_cnt - wr0), 32'd0);
    check("bad_cmd_err_sticky", {31'd0, cmd_err}, 32'd1);
    cs_low();
    check("bad_cmd_err_cleared", {31'd0, cmd_err}, 32'd0);
    cs_high();

    // Partial data byte is discarded
    wr0 = wr_cnt;
    cs_low();
    spi_xfer(8'h02, rx);
    spi_xfer(8'h10, rx);
    spi_bits(8'hEE, 5);
    cs_high();
    check("partial_no_write", wr_cnt - wr0, 32'd0);
    cs_low();
    spi_xfer(8'h03, rx);
    spi_xfer(8'h10, rx);
    spi_xfer(8'h00, rx); check("partial_readback", {24'd0, rx}, 32'h10);
    cs_high();

    // Last data bit coincides with deselect
    wr0 = wr_cnt;
    cs_low();
    spi_xfer(8'h02, rx);
    spi_xfer(8'h20, rx);
    spi_bits(8'h5A, 7);
    spi_mosi = 1'b0;
    #60;
    spi_sclk = 1'b1;
    spi_cs_n = 1'b1;
    #60;
    spi_sclk = 1'b0;
    #200;
    check("coinc_write_pulse", wr_cnt - wr0, 32'd1);
    check("coinc_mem", {24'd0, mem[8'h20]}, 32'h5A);
    check("coinc_state_idle", {29'd0, dut.state_q}, {29'd0, IDLE});
    cs_low();
    spi_xfer(8'h03, rx);
    spi_xfer(8'h20, rx);
    spi_xfer(8'h00, rx); check("coinc_readback", {24'd0, rx}, 32'h5A);
    cs_high();

    // Reset in the middle of a read
    cs_low();
    spi_xfer(8'h03, rx);
    spi_xfer(8'h00, rx);
    spi_xfer(8'h00, rx); check("midrst_byte0", {24'd0, rx}, 32'h33);
    spi_bits(8'h00, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs",
          {24'd0, spi_miso, ram_if.ram_ce, ram_if.ram_oce, ram_if.ram_wre, busy, cmd_err, 2'b00}, 32'd0);
    check("midrst_ad_din", {16'd0, ram_if.ram_ad, ram_if.ram_din}, 32'd0);
    check("midrst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
    #9;
    spi_cs_n = 1'b1;
    #40;
    rst_n = 1'b1;
    #100;
    rd0 = rd_cnt;
    cs_low();
    spi_xfer(8'h03, rx);
    spi_xfer(8'h01, rx);
    spi_xfer(8'h00, rx); check("postrst_byte0", {24'd0, rx}, 32'h32);
    cs_high();
    check("postrst_pulses", rd_cnt - rd0, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
